// File: rtl/inst_fetch.sv
// IF-stage fetch unit: owns the PC, issues one word fetch at a time over a
// req/ack handshake and presents if_pc/if_inst to the IF/ID register.
// Branches carry one delay slot; an exception flush redirects with top priority.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StBoot, StFetch, StHeld, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;

  logic        hold;
  logic [31:0] br_tgt_in;
  logic [31:0] flush_pc_in;
  logic [31:0] next_pc;
  logic        waiting;

  // Only stall[0] concerns this stage; the other bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign hold        = stall[0];
  assign br_tgt_in   = {branch_target_i[31:2], 2'b00};
  assign flush_pc_in = {new_pc[31:2], 2'b00};
  assign waiting     = ((state_q == StFetch) || (state_q == StDrain)) && !imem_ack;

  // PC of the instruction after the one being consumed; a same-cycle branch is newest.
  always_comb begin
    if (branch_flag_i) begin
      next_pc = br_tgt_in;
    end else if (br_pend_q) begin
      next_pc = br_tgt_q;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, pending branch, hold buffer, flush target, watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= 32'h0;
      buf_q      <= 32'h0;
      flush_pc_q <= 32'h0;
      wait_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      buf_q      <= buf_d;
      flush_pc_q <= flush_pc_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update; flush overrides everything decided above it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    buf_d      = buf_q;
    flush_pc_d = flush_pc_q;
    wait_d     = wait_q;
    err_d      = err_q;

    if (branch_flag_i) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_tgt_in;
    end

    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          if (!hold) begin
            pc_d      = next_pc;
            br_pend_d = 1'b0;
          end else begin
            buf_d   = imem_rdata;
            state_d = StHeld;
          end
        end
      end
      StHeld: begin
        if (!hold) begin
          pc_d      = next_pc;
          br_pend_d = 1'b0;
          state_d   = StFetch;
        end
      end
      StDrain: begin
        if (imem_ack) begin
          pc_d    = flush_pc_q;
          state_d = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase

    if (flush) begin
      br_pend_d = 1'b0;
      buf_d     = 32'h0;
      if (waiting) begin
        // Outstanding fetch must still complete; remember where to go afterwards.
        flush_pc_d = flush_pc_in;
        state_d    = StDrain;
      end else begin
        pc_d    = flush_pc_in;
        state_d = StFetch;
      end
    end

    // Watchdog saturates at WAIT_MAX so it cannot wrap back to zero.
    if (imem_ack) begin
      wait_d = 32'h0;
    end else if (waiting) begin
      if (wait_q < WAIT_MAX) begin
        wait_d = wait_q + 32'd1;
      end
      if (wait_q + 32'd1 >= WAIT_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  // Output decode from state and same-cycle handshake.
  always_comb begin
    imem_req    = (state_q == StFetch) || (state_q == StDrain);
    imem_addr   = {pc_q[31:2], 2'b00};
    if_pc       = pc_q;
    if_inst     = 32'h0;
    stallreq_if = waiting || (state_q == StDrain);
    fetch_err   = err_q;
    if (!flush) begin
      if ((state_q == StFetch) && imem_ack) begin
        if_inst = imem_rdata;
      end else if (state_q == StHeld) begin
        if_inst = buf_q;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, zero-bubble fetch, wait states, stall
// hold, branch delay slot, flush drain, watchdog, PC wrap and mid-fetch reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        fetch_err;

  int tests  = 0;
  int failed = 0;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .WAIT_MAX (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush           (flush),
    .new_pc          (new_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive handshake inputs for this cycle and let combinational outputs settle.
  task automatic drive(input logic ack, input logic [31:0] rdata);
    imem_ack   = ack;
    imem_rdata = rdata;
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    stall           = 6'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    flush           = 1'b0;
    new_pc          = 32'h0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    tick();
    tick();

    // Reset values
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_inst",  if_inst, 32'h0);
    check("rst_stall", {31'b0, stallreq_if}, 32'd0);
    check("rst_err",   {31'b0, fetch_err}, 32'd0);

    // BOOT cycle: no request yet
    rst = 1'b1;
    drive(1'b1, 32'h0);
    check("boot_req", {31'b0, imem_req}, 32'd0);
    tick();

    // Zero-bubble fetch 0,4,8,C with ack every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hAAAA_0000 + 32'(i * 4));
      check("seq_req",   {31'b0, imem_req}, 32'd1);
      check("seq_addr",  imem_addr, 32'(i * 4));
      check("seq_inst",  if_inst, 32'hAAAA_0000 + 32'(i * 4));
      check("seq_stall", {31'b0, stallreq_if}, 32'd0);
      tick();
    end

    // Three wait cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0);
      check("wait_addr",  imem_addr, 32'h10);
      check("wait_stall", {31'b0, stallreq_if}, 32'd1);
      check("wait_inst",  if_inst, 32'h0);
      tick();
    end
    drive(1'b1, 32'h1111_0010);
    check("wait_ack_inst",  if_inst, 32'h1111_0010);
    check("wait_ack_stall", {31'b0, stallreq_if}, 32'd0);
    tick();
    drive(1'b0, 32'h0);
    check("wait_next_addr", imem_addr, 32'h14);

    // Ack while stalled at 0x14 -> HELD for two cycles
    stall = 6'b000001;
    drive(1'b1, 32'h2402_0005);
    check("held_ack_inst", if_inst, 32'h2402_0005);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0);
      check("held_req",   {31'b0, imem_req}, 32'd0);
      check("held_inst",  if_inst, 32'h2402_0005);
      check("held_pc",    if_pc, 32'h14);
      check("held_stall", {31'b0, stallreq_if}, 32'd0);
      tick();
    end
    stall = 6'b000000;
    drive(1'b0, 32'h0);
    check("held_rel_inst", if_inst, 32'h2402_0005);
    tick();
    drive(1'b0, 32'h0);
    check("held_next_addr", imem_addr, 32'h18);
    check("held_next_req",  {31'b0, imem_req}, 32'd1);

    // Run 0x18,0x1C,0x20 to reach 0x24
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0);
      tick();
    end
    // Branch to 0x100 while 0x24 waits; 0x24 is the delay slot
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0100;
    drive(1'b0, 32'h0);
    check("br_addr", imem_addr, 32'h24);
    tick();
    branch_flag_i = 1'b0;
    drive(1'b0, 32'h0);
    check("br_hold_addr", imem_addr, 32'h24);
    tick();
    drive(1'b1, 32'h0000_0024);
    check("br_slot_inst", if_inst, 32'h0000_0024);
    check("br_slot_pc",   if_pc, 32'h24);
    tick();
    drive(1'b1, 32'h0);
    check("br_target", imem_addr, 32'h100);
    tick();
    drive(1'b1, 32'h0);
    check("br_cleared", imem_addr, 32'h104);

    // Same-cycle branch with misaligned target 0x43 -> 0x40
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0043;
    drive(1'b1, 32'h0);
    tick();
    branch_flag_i = 1'b0;
    drive(1'b0, 32'h0);
    check("br_align", imem_addr, 32'h40);

    // Pending branch to 0x200, then flush to 0x180 during outstanding fetch at 0x40
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0200;
    drive(1'b0, 32'h0);
    tick();
    branch_flag_i = 1'b0;
    flush         = 1'b1;
    new_pc        = 32'h0000_0180;
    drive(1'b0, 32'h0);
    check("fl_inst",  if_inst, 32'h0);
    check("fl_addr",  imem_addr, 32'h40);
    check("fl_stall", {31'b0, stallreq_if}, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("drain_req",   {31'b0, imem_req}, 32'd1);
    check("drain_addr",  imem_addr, 32'h40);
    check("drain_stall", {31'b0, stallreq_if}, 32'd1);
    tick();
    drive(1'b1, 32'hDEAD_BEEF);
    check("drain_ack_inst", if_inst, 32'h0);
    check("drain_ack_addr", imem_addr, 32'h40);
    tick();
    drive(1'b1, 32'h0);
    check("fl_target", imem_addr, 32'h180);
    tick();
    drive(1'b0, 32'h0);
    check("fl_br_dropped", imem_addr, 32'h184);

    // Watchdog: eight cycles without ack at 0x184
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 32'h0);
      tick();
    end
    check("wd_before", {31'b0, fetch_err}, 32'd0);
    drive(1'b0, 32'h0);
    tick();
    check("wd_set",  {31'b0, fetch_err}, 32'd1);
    check("wd_addr", imem_addr, 32'h184);
    drive(1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0);
    check("wd_sticky", {31'b0, fetch_err}, 32'd1);
    check("wd_next",   imem_addr, 32'h188);

    // Flush with same-cycle ack to 0xFFFF_FFFC, then wrap to 0
    flush  = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    drive(1'b1, 32'h1234_5678);
    check("flack_inst", if_inst, 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h0);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 32'h0);
    check("wrap_zero", imem_addr, 32'h0);
    tick();

    // Reset mid-fetch at 0x4
    drive(1'b0, 32'h0);
    check("mid_req",  {31'b0, imem_req}, 32'd1);
    check("mid_addr", imem_addr, 32'h4);
    rst = 1'b0;
    #1;
    check("mid_rst_req",  {31'b0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_err",  {31'b0, fetch_err}, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'hCAFE_0004);
    check("mid_boot_req",  {31'b0, imem_req}, 32'd0);
    check("mid_boot_inst", if_inst, 32'h0);
    tick();
    drive(1'b1, 32'hCAFE_0000);
    check("mid_restart_addr", imem_addr, 32'h0);
    check("mid_restart_inst", if_inst, 32'hCAFE_0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
